// File: rtl/encoder_pending_queue_pkg.sv
// Shared definitions for the pending-queue request encoder: selection modes,
// a constant-evaluable log2 helper and a "more than one bit set" test.
package encoder_pkg;

    localparam int MODE_PRIO = 0;  // lowest pending index wins
    localparam int MODE_RR   = 1;  // search starts at the rotating pointer

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // True when at least two bits are set: clearing the lowest set bit
    // leaves something behind.
    function automatic logic popcount_gt1(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/encoder_pending_queue_if.sv
// Request / index bundle for the pending-queue encoder.
// Handshake: the consumer takes y when vld && rdy on a rising clk edge; while
// vld is high and rdy is low, y and vld hold their values unchanged.
// e is an active-low enable gating request capture and new loads.
interface encoder_pending_queue_if #(
    parameter int N = 4,
    parameter int W = encoder_pkg::clog2(N)
);
    logic         e;
    logic [N-1:0] w;
    logic         rdy;
    logic         vld;
    logic [W-1:0] y;
    logic         multi;
    logic         drop;
    logic         busy;

    modport master (output e, w, rdy, input vld, y, multi, drop, busy);
    modport slave  (input e, w, rdy, output vld, y, multi, drop, busy);
endinterface

// File: rtl/encoder_pending_queue_sel.sv
// Combinational wrap-around priority search: returns the first set bit of vec
// found at or after start, wrapping from N-1 back to 0.
module enc_prio_select
    import encoder_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         any,
    output logic [W-1:0] idx
);

    // Position of the i-th candidate after start, folded back into 0..N-1.
    function automatic logic [W-1:0] wrap_pos(input logic [W-1:0] s, input int i);
        int j;
        j = int'(s) + i;
        if (j >= N) j = j - N;
        return W'(j);
    endfunction

    // Scan N candidates from start; the first hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && vec[wrap_pos(start, i)]) begin
                any = 1'b1;
                idx = wrap_pos(start, i);
            end
        end
    end

endmodule

// File: rtl/encoder_pending_queue.sv
// Pending-queue request encoder: requests are captured into sticky pending
// bits and handed out one encoded index per accepted handshake, in either
// fixed-priority or round-robin order.
module encoder_pending_queue
    import encoder_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = clog2(N),
    parameter int MODE       = MODE_PRIO,
    parameter int ACT_LOW_IN = 1
) (
    input logic                    clk,
    input logic                    rst,
    encoder_pending_queue_if.slave bus
);

    logic [N-1:0] pend;
    logic [N-1:0] req;
    logic [N-1:0] load_mask;
    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] sel;
    logic [W-1:0] y_q;
    logic         sel_any;
    logic         vld_q;
    logic         multi_q;
    logic         drop_q;
    logic         slot_free;
    logic         load;

    // Normalise request polarity; a disabled encoder sees no requests.
    always_comb begin
        req = '0;
        if (!bus.e) req = (ACT_LOW_IN != 0) ? ~bus.w : bus.w;
    end

    // Fixed priority always searches from index 0.
    assign start = (MODE == MODE_RR) ? ptr : '0;

    enc_prio_select #(.N(N), .W(W)) u_sel (
        .vec   (pend),
        .start (start),
        .any   (sel_any),
        .idx   (sel)
    );

    // The output slot can take a new index when empty or being consumed now.
    assign slot_free = ~vld_q | bus.rdy;
    assign load      = slot_free & ~bus.e & sel_any;

    // One-hot mask of the pending bit being handed to the output this edge.
    always_comb begin
        load_mask = '0;
        if (load) load_mask[sel] = 1'b1;
    end

    // Sticky capture; a fresh request on the bit being loaded re-arms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= '0;
            multi_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            pend    <= (pend & ~load_mask) | req;
            multi_q <= popcount_gt1(32'(req));
            drop_q  <= |(req & pend & ~load_mask);
        end
    end

    // Output register: load a new index, go idle, or hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else if (load) begin
            y_q   <= sel;
            vld_q <= 1'b1;
        end else if (slot_free) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end
    end

    // Round-robin pointer moves just past each issued index, wrapping at N-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && MODE == MODE_RR) begin
            ptr <= (sel == W'(N - 1)) ? '0 : sel + W'(1);
        end
    end

    assign bus.vld   = vld_q;
    assign bus.y     = y_q;
    assign bus.multi = multi_q;
    assign bus.drop  = drop_q;
    assign bus.busy  = (|pend) | vld_q;

endmodule
